// File: rtl/frame_stream_reader.sv
// frame_stream_reader: reads one frame from a synchronous-read frame buffer in raster order.
// Output is a valid/ready pixel stream with sof/eol/eof markers through a 2-entry FWFT FIFO.
module frame_stream_reader #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_addr,
    input  logic [PIXEL_BITS-1:0] mem_rd_data,
    output logic [PIXEL_BITS-1:0] pixel_out,
    output logic                  pixel_out_valid,
    input  logic                  pixel_out_ready,
    output logic                  pixel_out_sof,
    output logic                  pixel_out_eol,
    output logic                  pixel_out_eof
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int FW = PIXEL_BITS + 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_done;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;

    logic                  r_vld_p1;
    logic                  r_sof_p1;
    logic                  r_eol_p1;
    logic                  r_eof_p1;

    logic [FW-1:0]         r_fifo [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_rd_en;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_frame_last;
    logic [FW-1:0]         w_head;
    logic [FW-1:0]         w_fifo_in;

    assign w_pop        = (r_count != 2'd0) && pixel_out_ready;
    assign w_push       = r_vld_p1;
    // Occupancy seen next cycle: buffered + returning - leaving; keeps the FIFO from overflowing.
    assign w_occ        = 3'(r_count) + 3'(r_vld_p1) - 3'(w_pop);
    assign w_rd_en      = (r_state == S_STREAM) && (w_occ <= 3'd1);
    assign w_x_last     = (r_x == XW'(IMG_WIDTH - 1));
    assign w_y_last     = (r_y == YW'(IMG_HEIGHT - 1));
    assign w_frame_last = w_x_last && w_y_last;
    assign w_head       = r_fifo[r_rptr];
    assign w_fifo_in    = {r_eof_p1, r_eol_p1, r_sof_p1, mem_rd_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !r_done) begin
                        r_state <= S_STREAM;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_rd_en) begin
                        r_addr <= w_frame_last ? '0 : r_addr + ADDR_BITS'(1);
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= w_y_last ? '0 : r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                        if (w_frame_last) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_pop && w_head[FW-1]) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // p0 -> p1: read issued, markers travel with the one-cycle memory latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        r_sof_p1 <= (r_x == '0) && (r_y == '0);
        r_eol_p1 <= w_x_last;
        r_eof_p1 <= w_frame_last;
    end

    // p1 -> FIFO: returned pixel is pushed, head is presented downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_fifo_in;
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign mem_rd_en       = w_rd_en;
    assign mem_addr        = r_addr;
    assign pixel_out_valid = (r_count != 2'd0);
    assign pixel_out       = pixel_out_valid ? w_head[PIXEL_BITS-1:0] : '0;
    assign pixel_out_sof   = pixel_out_valid & w_head[FW-3];
    assign pixel_out_eol   = pixel_out_valid & w_head[FW-2];
    assign pixel_out_eof   = pixel_out_valid & w_head[FW-1];

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader: 4x3 frame instance with a scoreboard plus a 2x2 minimal-frame instance.
module tb_frame_stream_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AB = 4;
    localparam int PB = 8;

    logic          clk = 1'b0;
    logic          reset, start, ready;
    logic          busy, done, rd_en, valid, sof, eol, eof;
    logic [AB-1:0] addr;
    logic [PB-1:0] rd_data, pix_o;

    logic          start_b, ready_b;
    logic          busy_b, done_b, rd_en_b, valid_b, sof_b, eol_b, eof_b;
    logic [1:0]    addr_b;
    logic [PB-1:0] rd_data_b, pix_b;

    assign ready_b = 1'b1;

    always #5 clk = ~clk;

    frame_stream_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(PB), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(rd_en), .mem_addr(addr), .mem_rd_data(rd_data),
        .pixel_out(pix_o), .pixel_out_valid(valid), .pixel_out_ready(ready),
        .pixel_out_sof(sof), .pixel_out_eol(eol), .pixel_out_eof(eof)
    );

    frame_stream_reader #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .PIXEL_BITS(PB), .ADDR_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
        .pixel_out(pix_b), .pixel_out_valid(valid_b), .pixel_out_ready(ready_b),
        .pixel_out_sof(sof_b), .pixel_out_eol(eol_b), .pixel_out_eof(eof_b)
    );

    function automatic logic [7:0] pix(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Frame buffer: one-cycle read latency, garbage when not read.
    always @(posedge clk) rd_data   <= rd_en   ? pix(int'(addr))   : 8'hEE;
    always @(posedge clk) rd_data_b <= rd_en_b ? pix(int'(addr_b)) : 8'hEE;

    typedef struct {
        logic start;
        logic ready;
        logic busy;
        logic rd_en;
        logic valid;
        logic done;
    } vec_t;

    vec_t vecs[16];

    int   total = 0;
    int   bad   = 0;
    int   exp_idx, n_reads, n_pops, done_cnt, done_cyc, cyc;
    logic prev_valid, prev_ready, prev_sof, prev_eol, prev_eof;
    logic [PB-1:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_frame();
        exp_idx    = 0;
        n_reads    = 0;
        n_pops     = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        cyc        = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_sof   = 1'b0;
        prev_eol   = 1'b0;
        prev_eof   = 1'b0;
        prev_data  = '0;
    endtask

    // Scoreboard for the 4x3 instance, evaluated once per cycle mid-period.
    task automatic check_cycle();
        chk("outstanding_le2", 32'((n_reads - n_pops) <= 2), 32'd1);
        if (rd_en) begin
            chk("rd_only_busy", 32'(busy), 32'd1);
            chk("rd_addr", 32'(addr), 32'(n_reads));
            chk("rd_count_le_N", 32'(n_reads < N), 32'd1);
            n_reads++;
        end
        if (prev_valid && !prev_ready)
            chk("hold_stable", 32'({valid, sof, eol, eof, pix_o}),
                32'({1'b1, prev_sof, prev_eol, prev_eof, prev_data}));
        if (valid && ready) begin
            chk("px_data", 32'(pix_o), 32'(pix(exp_idx)));
            chk("px_sof", 32'(sof), 32'(exp_idx == 0));
            chk("px_eol", 32'(eol), 32'((exp_idx % W) == W - 1));
            chk("px_eof", 32'(eof), 32'(exp_idx == N - 1));
            exp_idx++;
            n_pops++;
        end else if (!valid) begin
            chk("idle_zero", 32'({pix_o, sof, eol, eof}), 32'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_valid = valid;
        prev_ready = ready;
        prev_sof   = sof;
        prev_eol   = eol;
        prev_eof   = eof;
        prev_data  = pix_o;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic finish_frame(input string tag, input int budget, input bit rnd);
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
        chk({tag, "_pixels"}, 32'(exp_idx), 32'(N));
        chk({tag, "_reads"}, 32'(n_reads), 32'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < 16; c++) begin
            vecs[c].start = (c == 0);
            vecs[c].ready = 1'b1;
            vecs[c].busy  = (c >= 1 && c <= 14);
            vecs[c].rd_en = (c >= 1 && c <= 12);
            vecs[c].valid = (c >= 3 && c <= 14);
            vecs[c].done  = (c == 15);
        end

        reset   = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({busy, done, rd_en}), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_stream", 32'({valid, sof, eol, eof, pix_o}), 32'd0);
        chk("rst_b", 32'({busy_b, done_b, rd_en_b, valid_b}), 32'd0);
        reset = 1'b0;

        // Ready held high: timing table
        new_frame();
        for (int c = 0; c < 16; c++) begin
            start = vecs[c].start;
            ready = vecs[c].ready;
            @(negedge clk);
            chk("t1_busy", 32'(busy), 32'(vecs[c].busy));
            chk("t1_rd_en", 32'(rd_en), 32'(vecs[c].rd_en));
            chk("t1_valid", 32'(valid), 32'(vecs[c].valid));
            chk("t1_done", 32'(done), 32'(vecs[c].done));
            check_cycle();
            advance();
        end
        start = 1'b0;
        chk("t1_pixels", 32'(exp_idx), 32'(N));
        chk("t1_reads", 32'(n_reads), 32'(N));
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Random backpressure
        for (int f = 0; f < 3; f++) begin
            new_frame();
            start = 1'b1;
            ready = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            finish_frame("t2", 400, 1'b1);
        end

        // Ready low for 10 cycles from start
        new_frame();
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("t3_reads_held", 32'(n_reads), 32'd2);
        chk("t3_no_pop", 32'(n_pops), 32'd0);
        ready = 1'b1;
        finish_frame("t3", 100, 1'b0);

        // start in cycle 5 and in the done cycle ignored; start one cycle later accepted
        new_frame();
        ready = 1'b1;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) begin
            start = (c == 5 || c == 15);
            tick();
        end
        chk("t4_done_cyc", 32'(done_cyc), 32'd15);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_reads", 32'(n_reads), 32'(N));
        new_frame();
        start = 1'b1;
        sample();
        chk("t4_idle_after_done", 32'(busy), 32'd0);
        advance();
        start = 1'b0;
        finish_frame("t4b", 100, 1'b0);
        chk("t4b_done_cyc", 32'(done_cyc), 32'd15);

        // Reset right after pixel 5 handshake
        new_frame();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && exp_idx < 6; k++) tick();
        chk("t5_reached_px5", 32'(exp_idx), 32'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        new_frame();
        sample();
        chk("t5_rst_ctrl", 32'({busy, done, rd_en}), 32'd0);
        chk("t5_rst_stream", 32'({valid, sof, eol, eof, pix_o}), 32'd0);
        chk("t5_rst_addr", 32'(addr), 32'd0);
        advance();
        repeat (3) begin
            sample();
            chk("t5_no_stray_valid", 32'(valid), 32'd0);
            advance();
        end
        new_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame("t5b", 100, 1'b0);

        // Minimal 2x2 frame
        new_frame();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            sample();
            chk("t6_valid", 32'(valid_b), 32'(c >= 3 && c <= 6));
            chk("t6_done", 32'(done_b), 32'(c == 7));
            if (c >= 3 && c <= 6) begin
                chk("t6_data", 32'(pix_b), 32'(pix(c - 3)));
                chk("t6_sof", 32'(sof_b), 32'(c == 3));
                chk("t6_eol", 32'(eol_b), 32'(((c - 3) % 2) == 1));
                chk("t6_eof", 32'(eof_b), 32'(c == 6));
            end
            advance();
        end
        chk("t6_idle", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
